// File: rtl/f_pc_ctrl_pkg.sv
// Shared next-PC select codes and default fetch constants for the F stage.
package f_pc_ctrl_pkg;

    localparam logic [2:0] PC_4  = 3'd0;
    localparam logic [2:0] PC_BR = 3'd1;
    localparam logic [2:0] PC_J  = 3'd2;
    localparam logic [2:0] PC_JR = 3'd3;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

    // Word offset of a conditional branch, sign-extended and scaled to bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/f_pc_ctrl_npc_calc.sv
// Combinational branch/jump target and taken resolution for the D-stage instruction.
module f_pc_ctrl_npc_calc
    import f_pc_ctrl_pkg::*;
(
    input  logic [2:0]  i_pc_src,
    input  logic        i_cmp,
    input  logic [31:0] i_pc,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_rs,
    output logic [31:0] o_target,
    output logic        o_taken
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    assign w_pc4       = i_pc + 32'd4;
    assign w_br_target = w_pc4 + br_offset(i_imm26[15:0]);
    assign w_j_target  = {w_pc4[31:28], i_imm26, 2'b00};

    // Codes 4-7 fall through to the default: not taken, sequential fetch.
    always_comb begin
        o_target = w_pc4;
        o_taken  = 1'b0;
        case (i_pc_src)
            PC_BR: begin
                o_target = w_br_target;
                o_taken  = i_cmp;
            end
            PC_J: begin
                o_target = w_j_target;
                o_taken  = 1'b1;
            end
            PC_JR: begin
                o_target = i_rs;
                o_taken  = 1'b1;
            end
            default: begin
                o_target = w_pc4;
                o_taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC register with exception/eret/stall/redirect priority and IF/ID flush.
module f_pc_ctrl
    import f_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC     = EXC_PC_DEF,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int          IM_WORDS   = 4096,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  d_pc_src,
    input  logic        d_cmp,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] f_pc,
    output logic        f_adel,
    output logic [31:0] d_pc8,
    output logic        fd_flush
);

    // One bit wider so a memory ending at 2^32 does not wrap the limit to zero.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_target;
    logic        w_taken;

    f_pc_ctrl_npc_calc u_npc_calc (
        .i_pc_src (d_pc_src),
        .i_cmp    (d_cmp),
        .i_pc     (d_pc),
        .i_imm26  (d_imm26),
        .i_rs     (d_rs),
        .o_target (w_target),
        .o_taken  (w_taken)
    );

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (exc_req)
            w_pc_next = EXC_PC;
        else if (eret)
            w_pc_next = epc;
        else if (stall)
            w_pc_next = r_pc;
        else if (w_taken)
            w_pc_next = w_target;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    // Reset gates the flush so a stray exc_req during reset cannot clear IF/ID.
    always_comb begin
        fd_flush = 1'b0;
        if (!reset)
            fd_flush = exc_req | eret | ((DELAY_SLOT == 0) && w_taken && !stall);
    end

    assign f_pc   = r_pc;
    assign f_adel = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || ({1'b0, r_pc} >= IM_END);
    assign d_pc8  = d_pc + 32'd8;

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Scoreboard bench for f_pc_ctrl: a delay-slot and a no-delay-slot instance share stimulus.
module tb_f_pc_ctrl;

    localparam logic [2:0] C_PC4 = 3'd0;
    localparam logic [2:0] C_BR  = 3'd1;
    localparam logic [2:0] C_J   = 3'd2;
    localparam logic [2:0] C_JR  = 3'd3;

    typedef struct packed {
        logic        rst;
        logic [2:0]  src;
        logic        cmp;
        logic [31:0] dpc;
        logic [25:0] imm;
        logic [31:0] rs;
        logic        st;
        logic        exc;
        logic        er;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_adel;
        logic        fl1;
        logic        fl0;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  d_pc_src = 3'd0;
    logic        d_cmp = 1'b0;
    logic [31:0] d_pc = 32'd0;
    logic [25:0] d_imm26 = 26'd0;
    logic [31:0] d_rs = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'd0;

    logic [31:0] f_pc, f_pc_ds0;
    logic        f_adel, f_adel_ds0;
    logic [31:0] d_pc8, d_pc8_ds0;
    logic        fd_flush, fd_flush_ds0;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    f_pc_ctrl #(.DELAY_SLOT(1)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .d_pc_src(d_pc_src), .d_cmp(d_cmp),
        .d_pc(d_pc), .d_imm26(d_imm26), .d_rs(d_rs), .exc_req(exc_req), .eret(eret),
        .epc(epc), .f_pc(f_pc), .f_adel(f_adel), .d_pc8(d_pc8), .fd_flush(fd_flush)
    );

    f_pc_ctrl #(.DELAY_SLOT(0)) u_dut_ds0 (
        .clk(clk), .reset(reset), .stall(stall), .d_pc_src(d_pc_src), .d_cmp(d_cmp),
        .d_pc(d_pc), .d_imm26(d_imm26), .d_rs(d_rs), .exc_req(exc_req), .eret(eret),
        .epc(epc), .f_pc(f_pc_ds0), .f_adel(f_adel_ds0), .d_pc8(d_pc8_ds0),
        .fd_flush(fd_flush_ds0)
    );

    function automatic vec_t mk(input logic rst, input logic [2:0] src, input logic cmp,
                                input logic [31:0] dpc, input logic [25:0] imm,
                                input logic [31:0] rs, input logic st, input logic exc,
                                input logic er, input logic [31:0] e_pc,
                                input logic [31:0] exp_pc, input logic exp_adel,
                                input logic fl1, input logic fl0);
        vec_t v;
        v.rst = rst; v.src = src; v.cmp = cmp; v.dpc = dpc; v.imm = imm; v.rs = rs;
        v.st = st; v.exc = exc; v.er = er; v.epc = e_pc;
        v.exp_pc = exp_pc; v.exp_adel = exp_adel; v.fl1 = fl1; v.fl0 = fl0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, queue its expectation, let combinational outputs settle.
    task automatic apply(input vec_t v);
        reset = v.rst; d_pc_src = v.src; d_cmp = v.cmp; d_pc = v.dpc; d_imm26 = v.imm;
        d_rs = v.rs; stall = v.st; exc_req = v.exc; eret = v.er; epc = v.epc;
        exp_q.push_back(v);
        #1;
    endtask

    task automatic test_reset();
        vec_t tv[$];
        vec_t e;
        tv.push_back(mk(1, C_J,   1, 32'h3008, 26'hC10, 0, 0, 1, 0, 0, 32'h3000, 0, 0, 0));
        tv.push_back(mk(1, C_PC4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300C, 0, 0, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            checks++;
            if (fd_flush !== tv[i].fl1 || fd_flush_ds0 !== tv[i].fl0) begin
                errors++;
                $display("FAIL reset[%0d] fd_flush: got ds1=%b ds0=%b, want %b/%b",
                         i, fd_flush, fd_flush_ds0, tv[i].fl1, tv[i].fl0);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (f_pc !== e.exp_pc || f_pc_ds0 !== e.exp_pc) begin
                errors++;
                $display("FAIL reset[%0d] f_pc: got %h/%h, want %h", i, f_pc, f_pc_ds0, e.exp_pc);
            end
            checks++;
            if (f_adel !== e.exp_adel || f_adel_ds0 !== e.exp_adel) begin
                errors++;
                $display("FAIL reset[%0d] f_adel: got %b/%b, want %b", i, f_adel, f_adel_ds0, e.exp_adel);
            end
        end
    endtask

    task automatic test_branch_jump();
        vec_t tv[$];
        vec_t e;
        tv.push_back(mk(0, C_BR,  1, 32'h3004, 26'h000FFFF, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 1));
        tv.push_back(mk(0, C_BR,  0, 32'h3004, 26'h000FFFF, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
        tv.push_back(mk(0, C_BR,  1, 32'h3000, 26'h0000010, 0, 0, 0, 0, 0, 32'h3044, 0, 0, 1));
        tv.push_back(mk(0, C_J,   0, 32'h3008, 26'h0000C10, 0, 0, 0, 0, 0, 32'h3040, 0, 0, 1));
        tv.push_back(mk(0, C_JR,  0, 0, 0, 32'h3002, 0, 0, 0, 0, 32'h3002, 1, 0, 1));
        tv.push_back(mk(0, 3'd5,  1, 32'h3004, 26'h000FFFF, 32'h5000, 0, 0, 0, 0, 32'h3006, 1, 0, 0));
        tv.push_back(mk(0, 3'd7,  1, 32'h3004, 26'h0000C10, 32'h5000, 0, 0, 0, 0, 32'h300A, 1, 0, 0));
        tv.push_back(mk(0, C_J,   0, 32'hF000_0000, 26'h3FFFFFF, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 1));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0));
        tv.push_back(mk(0, C_JR,  0, 0, 0, 32'h6FFC, 0, 0, 0, 0, 32'h6FFC, 0, 0, 1));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7000, 1, 0, 0));
        tv.push_back(mk(0, C_JR,  0, 0, 0, 32'h2FFC, 0, 0, 0, 0, 32'h2FFC, 1, 0, 1));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            checks++;
            if (fd_flush !== tv[i].fl1 || fd_flush_ds0 !== tv[i].fl0) begin
                errors++;
                $display("FAIL branch[%0d] fd_flush: got ds1=%b ds0=%b, want %b/%b",
                         i, fd_flush, fd_flush_ds0, tv[i].fl1, tv[i].fl0);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (f_pc !== e.exp_pc || f_pc_ds0 !== e.exp_pc) begin
                errors++;
                $display("FAIL branch[%0d] f_pc: got %h/%h, want %h", i, f_pc, f_pc_ds0, e.exp_pc);
            end
            checks++;
            if (f_adel !== e.exp_adel || f_adel_ds0 !== e.exp_adel) begin
                errors++;
                $display("FAIL branch[%0d] f_adel: got %b/%b, want %b", i, f_adel, f_adel_ds0, e.exp_adel);
            end
        end
    endtask

    task automatic test_stall_exc();
        vec_t tv[$];
        vec_t e;
        tv.push_back(mk(0, C_J,   0, 32'h3008, 26'h0000C10, 0, 1, 0, 0, 0, 32'h3000, 0, 0, 0));
        tv.push_back(mk(0, C_J,   0, 32'h3008, 26'h0000C10, 0, 1, 0, 0, 0, 32'h3000, 0, 0, 0));
        tv.push_back(mk(0, C_J,   0, 32'h3008, 26'h0000C10, 0, 0, 0, 0, 0, 32'h3040, 0, 0, 1));
        tv.push_back(mk(0, C_BR,  1, 32'h3004, 26'h000FFFF, 0, 1, 0, 0, 0, 32'h3040, 0, 0, 0));
        tv.push_back(mk(0, C_BR,  1, 32'h3004, 26'h000FFFF, 0, 1, 1, 0, 0, 32'h4180, 0, 1, 1));
        tv.push_back(mk(0, C_BR,  1, 32'h3004, 26'h000FFFF, 0, 0, 0, 1, 32'h3100, 32'h3100, 0, 1, 1));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 1, 1, 1, 32'h3100, 32'h4180, 0, 1, 1));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 1, 0, 1, 32'h3100, 32'h3100, 0, 1, 1));
        tv.push_back(mk(0, C_PC4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3104, 0, 0, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            checks++;
            if (fd_flush !== tv[i].fl1 || fd_flush_ds0 !== tv[i].fl0) begin
                errors++;
                $display("FAIL stall[%0d] fd_flush: got ds1=%b ds0=%b, want %b/%b",
                         i, fd_flush, fd_flush_ds0, tv[i].fl1, tv[i].fl0);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (f_pc !== e.exp_pc || f_pc_ds0 !== e.exp_pc) begin
                errors++;
                $display("FAIL stall[%0d] f_pc: got %h/%h, want %h", i, f_pc, f_pc_ds0, e.exp_pc);
            end
            checks++;
            if (f_adel !== e.exp_adel || f_adel_ds0 !== e.exp_adel) begin
                errors++;
                $display("FAIL stall[%0d] f_adel: got %b/%b, want %b", i, f_adel, f_adel_ds0, e.exp_adel);
            end
        end
    endtask

    task automatic test_d_pc8();
        logic [31:0] pcs [3];
        logic [31:0] want [3];
        pcs[0] = 32'h3000;      want[0] = 32'h3008;
        pcs[1] = 32'hFFFF_FFFC; want[1] = 32'h0000_0004;
        pcs[2] = 32'h7FFF_FFF8; want[2] = 32'h8000_0000;
        d_pc_src = C_PC4; exc_req = 1'b0; eret = 1'b0; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 2; s++) begin
                d_pc  = pcs[i];
                stall = s[0];
                #1;
                checks++;
                if (d_pc8 !== want[i] || d_pc8_ds0 !== want[i]) begin
                    errors++;
                    $display("FAIL d_pc8[%0d] stall=%0d: got %h/%h, want %h",
                             i, s, d_pc8, d_pc8_ds0, want[i]);
                end
                tick();
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_branch_jump();
        test_stall_exc();
        test_d_pc8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
